// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_kind_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [3:0] byte_en_t;

    // Store wins when both flags are set; an unsupported width for the winning type is a no-op.
    function automatic op_kind_t decode_op(input logic is_load, input logic is_store,
                                           input logic [2:0] funct3);
        op_kind_t kind;
        kind = OP_NOP;
        if (is_store) begin
            if (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W) kind = OP_STORE;
        end else if (is_load) begin
            if (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                funct3 == F3_BU || funct3 == F3_HU) kind = OP_LOAD;
        end
        return kind;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) mis = 1'b1;
        if (funct3 == F3_W && addr_lo != 2'b00) mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational load extraction: selects byte/half/word by address and extends it.
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data     = '0;
        case (funct3)
            F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
            F3_W:    data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and the registered data memory.
// Optional MISALIGN_TRAP_EN adds misalign_err and suppresses strobes for misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_is_load,
    input  logic             ex_is_store,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_addr,
    input  logic [XLEN-1:0]  ex_wdata,
    input  logic [REG_W-1:0] ex_rd,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output byte_en_t         mem_be,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [XLEN-1:0]  wb_data,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_we
`ifdef MISALIGN_TRAP_EN
    ,output logic            misalign_err
`endif
);

    lsu_state_t       state_q, state_d;
    op_kind_t         kind_q, kind_d;
    logic [2:0]       f3_q, f3_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [XLEN-1:0]  aligned;
    logic             mis;

`ifdef MISALIGN_TRAP_EN
    assign mis = is_misaligned(f3_q, addr_q[1:0]);
`else
    assign mis = 1'b0;
`endif

    load_align #(.XLEN(XLEN)) u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (f3_q),
        .data    (aligned)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        ex_ready  = 1'b0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        wb_valid  = 1'b0;
        wb_data   = '0;
        wb_rd     = '0;
        wb_we     = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_err = 1'b0;
`endif
        // Outputs are forced low during reset, even before the sampling edge.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    ex_ready = 1'b1;
                    if (ex_valid) begin
                        kind_d  = decode_op(ex_is_load, ex_is_store, ex_funct3);
                        f3_d    = ex_funct3;
                        addr_d  = ex_addr;
                        wdata_d = ex_wdata;
                        rd_d    = ex_rd;
                        state_d = (kind_d == OP_NOP) ? IDLE : ISSUE;
                    end
                end
                ISSUE: begin
                    mem_addr = {addr_q[XLEN-1:2], 2'b00};
`ifdef MISALIGN_TRAP_EN
                    misalign_err = mis;
`endif
                    if (kind_q == OP_STORE) begin
                        mem_wr = !mis;
                        case (f3_q)
                            F3_B: begin
                                mem_wdata = {4{wdata_q[7:0]}};
                                mem_be    = 4'b0001 << addr_q[1:0];
                            end
                            F3_H: begin
                                mem_wdata = {2{wdata_q[15:0]}};
                                mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                            end
                            default: begin
                                mem_wdata = wdata_q;
                                mem_be    = 4'b1111;
                            end
                        endcase
                        state_d = IDLE;
                    end else begin
                        mem_rd  = !mis;
                        mem_be  = 4'b1111;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    wb_data_d = mis ? '0 : aligned;
                    state_d   = RESP;
                end
                RESP: begin
                    wb_valid = 1'b1;
                    wb_data  = wb_data_q;
                    wb_rd    = rd_q;
                    wb_we    = (rd_q != '0) && !mis;
                    if (wb_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            kind_q    <= OP_NOP;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            f3_q      <= f3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-addressed memory reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_wr, mem_rd;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, wb_ready, wb_we;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        mis_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    logic [31:0] dmem[int];
    logic [7:0]  ref_b[int];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_we(wb_we)
`ifdef MISALIGN_TRAP_EN
        ,.misalign_err(mis_out)
`endif
    );
`ifndef MISALIGN_TRAP_EN
    assign mis_out = 1'b0;
`endif

    // Registered data memory seen by the DUT.
    always @(posedge clk) begin
        if (mem_wr) begin
            logic [31:0] w;
            w = dmem.exists(int'(mem_addr >> 2)) ? dmem[int'(mem_addr >> 2)] : 32'h0;
            for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            dmem[int'(mem_addr >> 2)] = w;
        end
        if (mem_rd)
            mem_rdata <= dmem.exists(int'(mem_addr >> 2)) ? dmem[int'(mem_addr >> 2)] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rb(input int a);
        return ref_b.exists(a) ? ref_b[a] : 8'h00;
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        dmem[a >> 2] = w;
        for (int i = 0; i < 4; i++) ref_b[(a & ~3) + i] = w[8*i +: 8];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_ready"}, {31'b0, ex_ready}, 32'h0);
        check({tag, ".mem_wr"},   {31'b0, mem_wr},   32'h0);
        check({tag, ".mem_rd"},   {31'b0, mem_rd},   32'h0);
        check({tag, ".mem_addr"}, mem_addr,          32'h0);
        check({tag, ".mem_wdata"}, mem_wdata,        32'h0);
        check({tag, ".mem_be"},   {28'b0, mem_be},   32'h0);
        check({tag, ".wb_valid"}, {31'b0, wb_valid}, 32'h0);
        check({tag, ".wb_data"},  wb_data,           32'h0);
        check({tag, ".wb_rd"},    {27'b0, wb_rd},    32'h0);
        check({tag, ".wb_we"},    {31'b0, wb_we},    32'h0);
        check({tag, ".misalign"}, {31'b0, mis_out},  32'h0);
    endtask

    // Drives one operation and checks every phase against the reference model.
    // Called just after a falling edge with the DUT idle.
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input int stall);
        bit is_st, is_ld, mis;
        int wa, lane;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] exp_wd, exp_data, got;
        logic [3:0]  exp_be;
        is_st = st && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        is_ld = !st && ld && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = 0;
`ifdef MISALIGN_TRAP_EN
        mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
`endif
        wa = int'(a) & ~3;
        lane = (int'(a) >> 1) & 1;

        ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_addr = a; ex_wdata = wd; ex_rd = rd;
        check("idle.ex_ready", {31'b0, ex_ready}, 32'h1);
        @(negedge clk);
        ex_valid = 0; ex_is_load = 0; ex_is_store = 0;

        if (!is_st && !is_ld) begin
            check("nop.mem_wr", {31'b0, mem_wr}, 32'h0);
            check("nop.mem_rd", {31'b0, mem_rd}, 32'h0);
            check("nop.ex_ready", {31'b0, ex_ready}, 32'h1);
            check("nop.wb_valid", {31'b0, wb_valid}, 32'h0);
            return;
        end

        check("issue.ex_ready", {31'b0, ex_ready}, 32'h0);
        check("issue.mem_addr", mem_addr, 32'(wa));
        check("issue.misalign", {31'b0, mis_out}, {31'b0, mis});
        if (is_st) begin
            check("st.mem_wr", {31'b0, mem_wr}, {31'b0, !mis});
            check("st.mem_rd", {31'b0, mem_rd}, 32'h0);
            if (f3 == 3'd0) begin
                exp_wd = {4{wd[7:0]}};
                exp_be = 4'(1 << (int'(a) % 4));
                if (!mis) ref_b[int'(a)] = wd[7:0];
            end else if (f3 == 3'd1) begin
                exp_wd = {2{wd[15:0]}};
                exp_be = lane ? 4'hC : 4'h3;
                if (!mis) begin
                    ref_b[wa + 2*lane]     = wd[7:0];
                    ref_b[wa + 2*lane + 1] = wd[15:8];
                end
            end else begin
                exp_wd = wd;
                exp_be = 4'hF;
                if (!mis) for (int i = 0; i < 4; i++) ref_b[wa + i] = wd[8*i +: 8];
            end
            if (!mis) begin
                check("st.mem_wdata", mem_wdata, exp_wd);
                check("st.mem_be", {28'b0, mem_be}, {28'b0, exp_be});
            end
            @(negedge clk);
            check("st.ready_back", {31'b0, ex_ready}, 32'h1);
            check("st.no_strobe", {30'b0, mem_wr, mem_rd}, 32'h0);
            return;
        end

        check("ld.mem_rd", {31'b0, mem_rd}, {31'b0, !mis});
        check("ld.mem_wr", {31'b0, mem_wr}, 32'h0);
        check("ld.mem_be", {28'b0, mem_be}, 32'hF);
        b = rb(int'(a));
        h = {rb(wa + 2*lane + 1), rb(wa + 2*lane)};
        case (f3)
            3'd0: exp_data = {{24{b[7]}}, b};
            3'd4: exp_data = {24'h0, b};
            3'd1: exp_data = {{16{h[15]}}, h};
            3'd5: exp_data = {16'h0, h};
            default: exp_data = {rb(wa + 3), rb(wa + 2), rb(wa + 1), rb(wa)};
        endcase
        if (mis) exp_data = 32'h0;
        exp_q.push_back(exp_data);

        @(negedge clk);
        check("wait.wb_valid", {31'b0, wb_valid}, 32'h0);
        check("wait.mem_rd", {31'b0, mem_rd}, 32'h0);
        @(negedge clk);
        got = exp_q.pop_front();
        check("resp.wb_valid", {31'b0, wb_valid}, 32'h1);
        check("resp.wb_data", wb_data, got);
        check("resp.wb_rd", {27'b0, wb_rd}, {27'b0, rd});
        check("resp.wb_we", {31'b0, wb_we}, {31'b0, (rd != 0) && !mis});
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold.wb_valid", {31'b0, wb_valid}, 32'h1);
            check("hold.wb_data", wb_data, got);
            check("hold.ex_ready", {31'b0, ex_ready}, 32'h0);
        end
        wb_ready = 1;
        @(negedge clk);
        wb_ready = 0;
        check("done.wb_valid", {31'b0, wb_valid}, 32'h0);
        check("done.ex_ready", {31'b0, ex_ready}, 32'h1);
    endtask

    initial begin
        rst = 1; ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_funct3 = 0;
        ex_addr = 0; ex_wdata = 0; ex_rd = 0; wb_ready = 0; mem_rdata = 0;
        for (int i = 0; i < 16; i++) set_word(32'h100 + 4*i, $urandom);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 0;
        @(negedge clk);
        check("post_reset.ex_ready", {31'b0, ex_ready}, 32'h1);

        // Directed cases.
        do_op(0, 1, 3'd0, 32'h103, 32'h0000_00A5, 5'd0, 0);
        set_word(32'h100, 32'h12F3_4455);
        do_op(1, 0, 3'd0, 32'h102, 32'h0, 5'd7, 0);
        do_op(1, 0, 3'd4, 32'h102, 32'h0, 5'd7, 0);
        set_word(32'h200, 32'h8001_1234);
        do_op(1, 0, 3'd1, 32'h202, 32'h0, 5'd3, 4);
        do_op(1, 0, 3'd2, 32'h200, 32'h0, 5'd0, 1);
        do_op(1, 1, 3'd2, 32'h104, 32'hDEAD_BEEF, 5'd9, 0);
        do_op(1, 0, 3'd2, 32'h104, 32'h0, 5'd9, 0);
        do_op(1, 0, 3'd3, 32'h108, 32'h0, 5'd4, 0);
        do_op(0, 1, 3'd5, 32'h108, 32'h1234_5678, 5'd4, 0);
        do_op(0, 0, 3'd2, 32'h108, 32'h1234_5678, 5'd4, 0);
        do_op(0, 1, 3'd2, 32'h301, 32'hCAFE_F00D, 5'd0, 0);
        do_op(1, 0, 3'd5, 32'h10B, 32'h0, 5'd6, 0);

        // Reset while a load waits for memory data.
        ex_valid = 1; ex_is_load = 1; ex_funct3 = 3'd2; ex_addr = 32'h110; ex_rd = 5'd5;
        @(negedge clk);
        ex_valid = 0; ex_is_load = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check_all_zero("rst_wait");
        rst = 0;
        @(negedge clk);
        check("rst_wait.no_wb", {31'b0, wb_valid}, 32'h0);
        do_op(0, 1, 3'd2, 32'h110, 32'h0BAD_F00D, 5'd0, 0);
        do_op(1, 0, 3'd2, 32'h110, 32'h0, 5'd5, 0);

        // Randomized operations.
        for (int n = 0; n < 250; n++) begin
            int r;
            r = $urandom_range(0, 9);
            do_op(r == 1 || r >= 6, r >= 1 && r <= 5, 3'($urandom_range(0, 7)),
                  32'h100 + 32'($urandom_range(0, 63)), $urandom,
                  5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        check("scoreboard.empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between execute and the memory stage of the RISC-V pipeline.
- Accepts one load/store per handshake from execute and issues a single-cycle read/write strobe to the registered data memory.
- Performs byte-lane steering and byte enables for SB/SH/SW, and alignment plus sign/zero extension for LB/LH/LW/LBU/LHU.
- Returns load results to writeback through a valid/ready handshake.

Parameters:
- XLEN, 32, data and address width.
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute presents an operation.
- ex_ready  out  1  LSU accepts the operation this cycle.
- ex_is_load  in  1  operation is a load.
- ex_is_store  in  1  operation is a store.
- ex_funct3  in  3  RV32I width/sign code.
- ex_addr  in  XLEN  byte address from the ALU.
- ex_wdata  in  XLEN  store data (rs2).
- ex_rd  in  REG_W  load destination register.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  XLEN  word-aligned address.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_rdata  in  XLEN  registered read data, valid the cycle after mem_rd.
- wb_valid  out  1  load result available.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  XLEN  extended load data.
- wb_rd  out  REG_W  destination register.
- wb_we  out  1  register write enable (0 when rd==0).

Behaviour:
- Reset: one clock and one reset only (clk, rst). Reset is synchronous and active-high. While rst is high, and after the edge that samples it, every output is 0 (ex_ready, mem_*, wb_*). The state goes to IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ex_ready=1 only in IDLE with rst low.
  - Accept when ex_valid&&ex_ready, and latch funct3, addr, wdata, rd and the op type.
  - Go to ISSUE if the op is valid; otherwise it is a no-op and the state stays IDLE.
- ISSUE, one cycle:
  - Drive mem_addr={addr[31:2],2'b00}.
  - Store: mem_wr=1, then go to IDLE. A store takes 2 cycles accept-to-ready.
  - Load: mem_rd=1, mem_be=4'b1111, then go to WAIT.
- WAIT: capture mem_rdata at the end of the cycle, apply extraction by addr[1:0], then go to RESP.
- RESP:
  - wb_valid=1. wb_data, wb_rd and wb_we are held stable until wb_valid&&wb_ready, then go to IDLE.
  - Load latency: accept edge N; wb_valid is high from cycle N+3.
- Outside ISSUE: mem_wr, mem_rd, mem_addr, mem_wdata and mem_be are all 0.
- Store steering:
  - SB (000): mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<addr[1:0].
  - SH (001): mem_wdata={2{wdata[15:0]}}, mem_be=addr[1]?1100:0011.
  - SW (010): mem_wdata=wdata, mem_be=1111.
- Load extraction:
  - LB/LBU select byte addr[1:0]. LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend. LW passes through.
- Invalid or no-op operations:
  - Unsupported funct3 (load 011/110/111, store 011–111) is accepted as a no-op: no strobe, no writeback.
  - is_load and is_store both set: store wins.
  - Neither set: no-op.
- wb_we=0 when rd==0; the result is still handshaked.
- Reset mid-operation drops the in-flight request and any pending response. No strobe is issued after the reset edge.

Optional Feature:
- MISALIGN_TRAP_EN:
  - Defined: adds output misalign_err (1 bit, reset 0). A misaligned operation is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. It pulses misalign_err for the ISSUE cycle and suppresses mem_wr/mem_rd. A misaligned load still reaches RESP with wb_we=0 and wb_data=0.
  - Undefined: the port is absent and low address bits are ignored. Halfword uses addr[1] only; word uses addr[31:2] only.

Decomposition:
- Package lsu_pkg:
  - enum lsu_state_t {IDLE, ISSUE, WAIT, RESP}.
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - typedef logic [3:0] byte_en_t.
- Sub-module load_align: combinational; takes rdata, addr[1:0] and funct3, and produces the extended data. It is reused by writeback forwarding.

Test Plan:
- SB addr=0x103, wdata=0x000000A5 -> ISSUE cycle: mem_wr=1, mem_addr=0x100, mem_be=1000, mem_wdata=0xA5A5A5A5; ex_ready returns after 2 cycles.
- LB addr=0x102, memory word 0x12F3_4455, rd=7 -> wb_valid at N+3 with wb_data=0xFFFFFFF3, wb_rd=7, wb_we=1. The same access as LBU gives 0x000000F3.
- LH addr=0x202, word 0x8001_1234, wb_ready held low 4 cycles -> wb_data=0xFFFF8001 held stable; ex_ready stays 0 until the wb handshake.
- LW rd=0 -> wb_valid=1, wb_we=0; both is_load and is_store set -> only mem_wr pulses.
- rst asserted during WAIT -> next cycle all outputs 0, no wb_valid; a new SW after rst deasserts completes normally.
- MISALIGN_TRAP_EN, SW addr=0x301 -> misalign_err=1 for one cycle, mem_wr=0. Without the macro -> mem_wr=1, mem_addr=0x300, mem_be=1111.
